// File: rtl/spi_bridge_master.sv
// SPI master engine for the I2C-to-SPI bridge. It takes words from the front-end
// over valid/ready and shifts them out with runtime CPOL/CPHA, bit order and
// clock divide. Each received word comes back as a one-cycle rx pulse, and CS
// stays low across a burst until a word flagged last.
//
// state | meaning
// IDLE  | bus idle, CS released, sclk tracks cfg_cpol, accepting first word
// SETUP | CS asserted, first bit on mosi, one half-period lead-in
// SHIFT | one SCLK edge per half-period, 2*DATA_W edges per word
// WAIT  | mid-burst, CS held, sclk at idle level, accepting next word
// HOLD  | CS held one half-period, then released for one idle half-period
module spi_bridge_master #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   tx_cs,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD} state_t;

  localparam int EC_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  timer, div_q;
  logic [EC_W-1:0]   edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_sh_nxt;
  logic              cpol_q, cpha_q, lsb_q, last_q, hold_gap, rx_done, ready_en;
  logic              tick, accept, last_edge, odd_edge, do_sample, do_drive;

  // Out-of-range select codes leave every chip select released.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == CS_W'(i)) v[i] = 1'b0;
    return v;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Keeps tx_ready low until the first clock after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    accept    = 1'b0;
    busy      = (state != IDLE);
    tick      = (timer == '0);
    last_edge = (edge_cnt == LAST_EDGE);
    case (state)
      IDLE: begin
        tx_ready = ready_en;
        accept   = tx_valid && ready_en;
        if (accept) state_nxt = SETUP;
      end
      SETUP: if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && last_edge) state_nxt = last_q ? HOLD : WAIT;
      WAIT: begin
        tx_ready = ready_en;
        accept   = tx_valid && ready_en;
        if (accept) state_nxt = SETUP;
      end
      HOLD: if (tick && hold_gap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge role: which edges sample miso and which move mosi to the next bit
  always_comb begin
    odd_edge  = ~edge_cnt[0];
    do_sample = cpha_q ? ~odd_edge : odd_edge;
    // The first bit is already on mosi from SETUP, and nothing follows the last bit.
    do_drive  = cpha_q ? (odd_edge && (edge_cnt != '0)) : (~odd_edge && ~last_edge);
    tx_sh_nxt = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
  end

  // Datapath: half-period timer, shift registers, SPI pins and rx pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      timer    <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
      hold_gap <= 1'b0;
    end else begin
      rx_done  <= 1'b0;
      rx_valid <= rx_done;
      if (rx_done) rx_data <= rx_sh;
      case (state)
        IDLE: begin
          sclk     <= cfg_cpol;
          mosi     <= 1'b0;
          cs_n     <= '1;
          timer    <= cfg_div;
          hold_gap <= 1'b0;
          if (accept) begin
            div_q    <= cfg_div;
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            lsb_q    <= cfg_lsb_first;
            last_q   <= tx_last;
            tx_sh    <= tx_data;
            mosi     <= first_bit(tx_data, cfg_lsb_first);
            cs_n     <= cs_decode(tx_cs);
            edge_cnt <= '0;
          end
        end
        SETUP: timer <= tick ? div_q : timer - 1'b1;
        SHIFT: begin
          if (tick) begin
            timer    <= div_q;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (do_sample)
              rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
            if (do_drive) begin
              tx_sh <= tx_sh_nxt;
              mosi  <= lsb_q ? tx_sh_nxt[0] : tx_sh_nxt[DATA_W-1];
            end
            if (last_edge) rx_done <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        WAIT: begin
          sclk  <= cpol_q;
          timer <= div_q;
          if (accept) begin
            last_q   <= tx_last;
            tx_sh    <= tx_data;
            mosi     <= first_bit(tx_data, lsb_q);
            edge_cnt <= '0;
          end
        end
        HOLD: begin
          sclk <= cpol_q;
          if (tick) begin
            timer    <= div_q;
            hold_gap <= 1'b1;
            if (!hold_gap) cs_n <= '1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bridge_master.sv
// Bench for spi_bridge_master. A bus monitor records SCLK edges, the mosi bits
// seen at the sampling edges and any CS disturbance. Each word is compared with
// values worked out from the protocol rules: the word, the CS pattern, the
// latency formula and the miso pattern applied.
// Three selects are used so that a select code past the last output exists.
module tb_spi_bridge_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_div;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic       tx_valid, tx_ready, tx_last;
  logic [7:0] tx_data;
  logic [1:0] tx_cs;
  logic       rx_valid, busy, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [2:0] cs_n;

  int miso_mode = 0;  // 0 loopback, 1 tied high, 2 inverted loopback, 3 tied low
  int n_checks = 0;
  int n_pass = 0;

  // monitor state (written only by the monitor)
  int   mon_edges = 0;
  int   rx_cnt = 0;
  int   cs_err = 0;
  logic mon_bits[$];
  logic sclk_prev = 1'b0;
  // monitor controls (written only by the stimulus process)
  int         edge_base = 0;
  int         cs_base = 0;
  logic       cur_cpha = 1'b0;
  logic       cs_watch = 1'b0;
  logic [2:0] exp_cs_n = 3'b111;

  spi_bridge_master #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_cs(tx_cs), .tx_last(tx_last), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b1 :
                (miso_mode == 2) ? ~mosi : 1'b0;

  // Bus monitor on the inactive clock edge
  always @(negedge clk) begin
    if (sclk !== sclk_prev) begin
      mon_edges++;
      if ((((mon_edges - edge_base) % 2) == 1) == (cur_cpha == 1'b0))
        mon_bits.push_back(mosi);
    end
    sclk_prev = sclk;
    if (rx_valid === 1'b1) rx_cnt++;
    if (cs_watch && (cs_n !== exp_cs_n)) cs_err++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] model_rx(input logic [7:0] d, input int mode);
    case (mode)
      0:       return d;
      1:       return 8'hFF;
      2:       return ~d;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] model_cs(input logic [1:0] cs);
    logic [2:0] one;
    one = 3'b001;
    return (cs < 2'd3) ? ~(one << cs) : 3'b111;
  endfunction

  task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb, input int div);
    @(negedge clk);
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_lsb_first = lsb;
    cfg_div = 8'(div);
  endtask

  // Sends one word, checks its timing and data, and for a last word the CS release.
  task automatic run_word(input string tag, input logic [7:0] data, input logic [1:0] cs,
                          input logic last, input logic cpha_m, input logic lsb_m,
                          input int div_m, input logic [7:0] exp_rx, input logic [2:0] exp_cs);
    int n, lat, exp_lat, base_bits, h;
    logic [7:0] mw;
    exp_lat = (2 * 8 + 1) * (div_m + 1) + 1;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = data; tx_cs = cs; tx_last = last;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    cur_cpha = cpha_m;
    edge_base = mon_edges;
    base_bits = mon_bits.size();
    if (!cs_watch) begin
      cs_base = cs_err;
      exp_cs_n = exp_cs;
      cs_watch = 1'b1;
    end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (rx_valid !== 1'b1 && lat < exp_lat + 20);
    if (last) cs_watch = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_edges"}, 32'(mon_edges - edge_base), 32'd16);
    check({tag, "_mosi_bits"}, 32'(mon_bits.size() - base_bits), 32'd8);
    mw = '0;
    for (int i = 0; i < 8; i++)
      if (base_bits + i < mon_bits.size()) begin
        if (lsb_m) mw[i] = mon_bits[base_bits + i];
        else       mw[7 - i] = mon_bits[base_bits + i];
      end
    check({tag, "_mosi_word"}, 32'(mw), 32'(data));
    check({tag, "_cs_steady"}, 32'(cs_err - cs_base), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rx_pulse"}, 32'(rx_valid), 32'd0);
    if (last) begin
      h = 1;
      while (busy && h < 2 * (div_m + 1) + 20) begin @(posedge clk); #1; h++; end
      check({tag, "_hold_len"}, 32'(h), 32'(2 * (div_m + 1) - 1));
      check({tag, "_cs_release"}, 32'(cs_n), 32'b111);
    end
  endtask

  typedef struct {
    logic       cpol, cpha, lsb;
    int         div;
    logic [7:0] data;
    logic [1:0] cs;
    int         mmode;
    logic [7:0] exp_rx;
    logic [2:0] exp_cs_n;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic cp, ch, ls;
    logic [1:0] rcs;
    logic [7:0] d;
    int dv, nw, mm, rx0, n;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1,   8'hA5, 2'd0, 0, 8'hA5, 3'b110};  // mode 0, loopback
    vecs[1] = '{1'b1, 1'b1, 1'b1, 0,   8'h3C, 2'd0, 1, 8'hFF, 3'b110};  // mode 3, LSB first, miso high
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2,   8'h5A, 2'd3, 0, 8'h5A, 3'b111};  // select out of range
    vecs[3] = '{1'b0, 1'b1, 1'b0, 255, 8'h96, 2'd1, 2, 8'h69, 3'b101};  // largest divider
    vecs[4] = '{1'b1, 1'b0, 1'b1, 0,   8'hC1, 2'd2, 3, 8'h00, 3'b011};  // mode 2, miso low

    rst = 1'b1;
    cfg_div = 8'd1; cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
    tx_valid = 1'b0; tx_data = '0; tx_cs = '0; tx_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_cs_n", 32'(cs_n), 32'b111);
    check("reset_tx_ready", 32'(tx_ready), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(tx_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      set_cfg(vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, vecs[v].div);
      miso_mode = vecs[v].mmode;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_idle_sclk", v), 32'(sclk), 32'(vecs[v].cpol));
      run_word($sformatf("vec%0d", v), vecs[v].data, vecs[v].cs, 1'b1, vecs[v].cpha,
               vecs[v].lsb, vecs[v].div, vecs[v].exp_rx, vecs[v].exp_cs_n);
    end

    // Burst on select 1; later words carry other select codes, which must be ignored.
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    miso_mode = 0;
    rx0 = rx_cnt;
    run_word("burst_w1", 8'h11, 2'd1, 1'b0, 1'b0, 1'b0, 1, 8'h11, 3'b101);
    run_word("burst_w2", 8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1, 8'h22, 3'b101);
    run_word("burst_w3", 8'h33, 2'd2, 1'b1, 1'b0, 1'b0, 1, 8'h33, 3'b101);
    check("burst_rx_pulses", 32'(rx_cnt - rx0), 32'd3);

    // Reset in the middle of a word, at SCLK edge 7.
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hC3; tx_cs = 2'd0; tx_last = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    edge_base = mon_edges;
    rx0 = rx_cnt;
    n = 0;
    while ((mon_edges - edge_base) < 7 && n < 200) begin @(negedge clk); #1; n++; end
    check("rst_at_edge7", 32'(mon_edges - edge_base), 32'd7);
    rst = 1'b1;
    #1;
    check("rst_mid_cs_n", 32'(cs_n), 32'b111);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_mid_mosi", 32'(mosi), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_rx_pulse", 32'(rx_cnt - rx0), 32'd0);
    run_word("after_rst", 8'h6B, 2'd0, 1'b1, 1'b0, 1'b0, 1, 8'h6B, 3'b110);

    // Configuration changes mid-burst wait for the burst to finish.
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    run_word("cfg_w1", 8'h4E, 2'd0, 1'b0, 1'b0, 1'b0, 1, 8'h4E, 3'b110);
    @(negedge clk);
    cfg_cpol = 1'b1; cfg_div = 8'd3;
    repeat (3) @(negedge clk);
    check("cfg_wait_sclk", 32'(sclk), 32'd0);
    check("cfg_wait_busy", 32'(busy), 32'd1);
    run_word("cfg_w2", 8'hB7, 2'd0, 1'b1, 1'b0, 1'b0, 1, 8'hB7, 3'b110);
    repeat (2) @(negedge clk);
    check("cfg_new_idle_sclk", 32'(sclk), 32'd1);
    run_word("cfg_w3", 8'h1D, 2'd0, 1'b1, 1'b0, 1'b0, 3, 8'h1D, 3'b110);

    // Randomised bursts against the rule-based model.
    for (int b = 0; b < 20; b++) begin
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      ls = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      mm = $urandom_range(0, 3);
      rcs = 2'($urandom_range(0, 3));
      set_cfg(cp, ch, ls, dv);
      miso_mode = mm;
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_idle_sclk", b), 32'(sclk), 32'(cp));
      for (int w = 0; w < nw; w++) begin
        d = 8'($urandom);
        run_word($sformatf("rnd%0d_w%0d", b, w), d, (w == 0) ? rcs : 2'($urandom_range(0, 3)),
                 (w == nw - 1), ch, ls, dv, model_rx(d, mm), model_cs(rcs));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
